// File: rtl/beep_tone_ctrl_if.sv
// Key-event / buzzer bundle between the debouncers, the controller and the pin.
interface beep_tone_ctrl_if #(
    parameter int CH_NUM     = 4,
    parameter int TONE_DIV_W = 16,
    parameter int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic [CH_NUM-1:0]            keyflag;
    logic [CH_NUM-1:0]            keyvalue;
    logic [1:0]                   mode;
    logic [CH_NUM*TONE_DIV_W-1:0] tone_half;
    logic                         beep;
    logic                         beep_en;
    logic [CH_W-1:0]              active_ch;

    modport master (
        output keyflag, keyvalue, mode, tone_half,
        input  beep, beep_en, active_ch
    );

    modport slave (
        input  keyflag, keyvalue, mode, tone_half,
        output beep, beep_en, active_ch
    );
endinterface

// File: rtl/beep_tone_ctrl.sv
// Multi-channel key-to-buzzer controller: per-channel hold/toggle/one-shot
// request tracking, lowest-index arbitration and a shared tone generator.
module beep_tone_ctrl #(
    parameter int CH_NUM     = 4,
    parameter int TONE_DIV_W = 16,
    parameter int DUR_W      = 24,
    parameter int BEEP_DUR   = 12_500_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    beep_tone_ctrl_if.slave bus
);
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_MUTE    = 2'd3
    } mode_t;

    mode_t                 r_mode;
    logic [CH_NUM-1:0]     r_req;
    logic [DUR_W-1:0]      r_dur [CH_NUM];
    logic [TONE_DIV_W-1:0] r_tone_cnt;
    logic                  r_phase;
    logic                  r_beep;
    logic                  r_beep_en;
    logic [CH_W-1:0]       r_active_ch;

    logic [CH_NUM-1:0]     w_press;
    logic [CH_NUM-1:0]     w_rel;
    logic                  w_mode_chg;
    logic                  w_any;
    logic [CH_W-1:0]       w_win;
    logic [TONE_DIV_W-1:0] w_half;
    logic                  w_dc;
    logic                  w_restart;
    logic                  w_wrap;

    assign w_press    = bus.keyflag & ~bus.keyvalue;
    assign w_rel      = bus.keyflag &  bus.keyvalue;
    assign w_mode_chg = (bus.mode != r_mode);
    assign w_any      = |r_req;

    // Lowest-index requesting channel wins (descending scan, last hit sticks).
    always_comb begin
        w_win = '0;
        for (int unsigned i = CH_NUM; i > 0; i--) begin
            if (r_req[i-1]) w_win = CH_W'(i - 1);
        end
    end

    assign w_half    = bus.tone_half[int'(w_win)*TONE_DIV_W +: TONE_DIV_W];
    assign w_dc      = (w_half == '0);
    assign w_restart = w_any && (!r_beep_en || (w_win != r_active_ch));
    // A counter left above a shrunken half-period just runs on to all-ones and wraps.
    assign w_wrap    = (r_tone_cnt == (w_half - TONE_DIV_W'(1)));

    // Per-channel request bits and one-shot duration counters, cleared on mode change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode <= MODE_HOLD;
            r_req  <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) r_dur[i] <= '0;
        end else begin
            r_mode <= mode_t'(bus.mode);
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (w_mode_chg) begin
                    r_req[i] <= 1'b0;
                    r_dur[i] <= '0;
                end else begin
                    case (r_mode)
                        MODE_HOLD: begin
                            if (w_press[i])    r_req[i] <= 1'b1;
                            else if (w_rel[i]) r_req[i] <= 1'b0;
                        end
                        MODE_TOGGLE: begin
                            if (w_press[i]) r_req[i] <= ~r_req[i];
                        end
                        MODE_ONESHOT: begin
                            if (w_press[i]) begin
                                r_req[i] <= 1'b1;
                                r_dur[i] <= DUR_W'(BEEP_DUR - 1);
                            end else if (r_req[i]) begin
                                if (r_dur[i] == '0) r_req[i] <= 1'b0;
                                else                r_dur[i] <= r_dur[i] - DUR_W'(1);
                            end
                        end
                        default: begin
                            r_req[i] <= 1'b0;
                            r_dur[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Envelope, arbitration result and tone generator; restarts on enable or channel switch.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_beep_en   <= 1'b0;
            r_active_ch <= '0;
            r_tone_cnt  <= '0;
            r_phase     <= 1'b0;
            r_beep      <= 1'b0;
        end else if (!w_any) begin
            r_beep_en   <= 1'b0;
            r_active_ch <= '0;
            r_tone_cnt  <= '0;
            r_phase     <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_beep_en   <= 1'b1;
            r_active_ch <= w_win;
            if (w_restart) begin
                r_tone_cnt <= '0;
                r_phase    <= 1'b1;
                r_beep     <= 1'b1;
            end else if (w_wrap) begin
                r_tone_cnt <= '0;
                r_phase    <= ~r_phase;
                r_beep     <= w_dc | ~r_phase;
            end else begin
                r_tone_cnt <= r_tone_cnt + TONE_DIV_W'(1);
                r_beep     <= w_dc | r_phase;
            end
        end
    end

    assign bus.beep      = r_beep;
    assign bus.beep_en   = r_beep_en;
    assign bus.active_ch = r_active_ch;
endmodule

// File: doc/beep_tone_ctrl.md
# beep_tone_ctrl

Multi-channel key-to-buzzer controller. It takes `CH_NUM` debounced key event channels, each a one-cycle `keyflag` pulse plus a `keyvalue` level. Each channel is interpreted in one of three run-time modes: hold, toggle or one-shot. The lowest-index active channel drives a single buzzer output, either as a square-wave tone with a per-channel pitch or as a DC level for active buzzers. It sits between the key debounce block(s) and the board buzzer pin, replacing the single-key DC-only beep controller.

## Interface
Parameters:
- `CH_NUM`, 4 — number of key channels (1..16).
- `TONE_DIV_W`, 16 — width of each per-channel tone half-period field.
- `DUR_W`, 24 — width of the one-shot duration counter.
- `BEEP_DUR`, 12_500_000 — one-shot beep length in `sys_clk` cycles; must be 1..2^DUR_W-1.
- `CH_W`, derived — width of `active_ch`: `$clog2(CH_NUM)`, minimum 1.

Ports:
- `sys_clk`  in  1  — system clock.
- `sys_rst_n`  in  1  — reset, asynchronous, active-low.
- `keyflag`  in  CH_NUM  — bit i: one-cycle "key i changed state" pulse from the debouncer.
- `keyvalue`  in  CH_NUM  — bit i: debounced key i level; 0 = pressed, 1 = released. Only meaningful when `keyflag[i]`=1.
- `mode`  in  2  — 0 = hold, 1 = toggle, 2 = one-shot, 3 = muted.
- `tone_half`  in  CH_NUM*TONE_DIV_W  — field i is the half-period of channel i's tone in cycles; 0 = DC (steady high).
- `beep`  out  1  — buzzer drive, registered.
- `beep_en`  out  1  — envelope: some channel is requesting sound, registered.
- `active_ch`  out  CH_W  — index of the channel currently sounding; 0 when idle, registered.

## Operation
- Per channel there is a request bit `req[i]`. In one-shot mode each channel also has a `DUR_W` down-counter.
- A press event is `keyflag[i]`=1 with `keyvalue[i]`=0. A release event is `keyflag[i]`=1 with `keyvalue[i]`=1. `keyvalue` with no flag is ignored.
- Hold mode: press sets `req[i]`; release clears it.
- Toggle mode: press inverts `req[i]`; release is ignored.
- One-shot mode:
  - Press sets `req[i]` and loads the counter with BEEP_DUR-1.
  - The counter decrements each cycle while `req[i]`=1.
  - The edge where the counter is 0 clears `req[i]`.
  - A press during an active shot reloads the counter (retrigger). Release is ignored.
- Muted mode: all `req` are forced to 0 and events are ignored.
- Mode change: `mode` is registered internally. On any cycle where `mode` differs from the registered value, all `req` bits and counters clear, and events in that cycle are discarded.
- Arbitration: the lowest index with `req[i]`=1 wins. `beep_en` = OR of all `req`.
- Tone generator: one shared half-period counter (TONE_DIV_W bits) and a phase bit.
  - The counter and phase restart whenever `beep_en` rises or `active_ch` changes: phase=1, counter=0.
  - While enabled, the counter increments; at `tone_half[active_ch]`-1 it wraps to 0 and phase inverts.
  - `beep` = phase when the field is non-zero; `beep` = 1 when the field is 0.
  - When disabled, `beep`=0.
  - If `tone_half` changes mid-tone and the counter is already ≥ the new value-1, the counter wraps at its next compare or at all-ones. No lock-up.

## Timing
- Reset: `beep`=0, `beep_en`=0, `active_ch`=0, all `req`=0, counters=0, registered mode=0 (hold).
- An event sampled at edge E updates `req` at E. `beep_en`, `active_ch` and the first `beep`=1 appear at E+1.
- A release (hold) or toggle-off at edge E drops `beep_en` and `beep` to 0 at E+1.
- Tone: `beep` is high for exactly `tone_half` cycles, then low for `tone_half` cycles, repeating. `tone_half`=1 gives `sys_clk`/2.
- One-shot: `req[i]` is high for exactly BEEP_DUR cycles. `beep_en` is high for BEEP_DUR cycles, delayed by 1.
- Simultaneous press on several channels: all `req` set. The lowest index sounds; when it stops, the next index takes over on the following edge, with the tone restarted.
- Press and release on the same channel cannot occur in the same cycle, since there is one flag per channel.
- Asserting `sys_rst_n` low mid-beep forces all outputs low immediately (asynchronously).

## Test plan
- Hold, `tone_half[0]`=3: press ch0, release 20 cycles later. `beep_en` is high for 20 cycles starting 1 cycle after the press. `beep` pattern is 111000 repeating. All low 1 cycle after the release.
- DC compatibility, `tone_half[1]`=0, hold: press ch1. `beep`=1 steadily and `active_ch`=1. Release gives `beep`=0 on the next cycle.
- Toggle: press ch2, release ch2, press ch2. Sound starts after the first press, continues through the release, stops 1 cycle after the second press.
- One-shot, BEEP_DUR=10: press ch0, then retrigger at cycle 6. `beep_en` is high for 16 cycles total. A press while in mode 3 produces no output.
- Priority: ch3 is held; ch1 is pressed at cycle 10 and released at cycle 30. `active_ch` goes 3 → 1 at cycle 11 and 1 → 3 at cycle 31, and the tone restarts with phase=1 at each switch.
- Mode change while ch0 is active in hold mode: `beep_en`=0 one cycle after `mode` changes, with no spurious re-arm. Asynchronous reset mid-tone drives all outputs to 0.
